// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the 2-way, 16-byte-line instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_t;

    localparam int LINE_BYTES = 16;
    localparam int WORDS      = 4;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int WORD_SEL_W = $clog2(WORDS);

    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and 4-word line, one async read port and one write port.
module icache_way
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [WORD_SEL_W-1:0] rd_word,
    input  logic [TAG_W-1:0]      cmp_tag,
    output logic                  line_valid,
    output logic                  hit,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic                  tag_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [WORD_SEL_W-1:0] wr_word,
    input  logic [31:0]           wr_data,
    input  logic [TAG_W-1:0]      wr_tag
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][WORDS];

    assign line_valid = valid_q[rd_index];
    assign hit        = valid_q[rd_index] && (tag_mem[rd_index] == cmp_tag);
    assign rd_data    = data_mem[rd_index][rd_word];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= '0;
        end else if (tag_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache.sv
// Blocking 2-way set-associative instruction cache with line refill and round-robin replacement.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = 32 - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    state_t                state, state_next;
    logic [TAG_W-1:0]      tag_p1;
    logic [INDEX_W-1:0]    index_p1;
    logic [WORD_SEL_W-1:0] word_p1;
    logic                  victim_p1;
    logic [WORD_SEL_W-1:0] beat;
    logic [SETS-1:0]       rr_ptr;
    logic [31:0]           rdata_q;

    logic        hit0, hit1, lv0, lv1;
    logic [31:0] data0, data1, hit_word;
    logic        lookup_hit, lookup_miss, accept, fill_we, fill_last;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign lookup_hit  = (state == LOOKUP) && (hit0 || hit1);
    assign lookup_miss = (state == LOOKUP) && !(hit0 || hit1);
    assign accept      = aresetn && valid && ((state == IDLE) || lookup_hit);
    assign hit_word    = hit0 ? data0 : data1;
    assign fill_we     = (state == REFILL) && ret_valid;
    assign fill_last   = fill_we && ret_last;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = LOOKUP;
            LOOKUP:  if (!lookup_hit) state_next = MISS;
                     else if (valid)  state_next = LOOKUP;
                     else             state_next = IDLE;
            MISS:    if (rd_rdy) state_next = REFILL;
            REFILL:  if (ret_valid && ret_last) state_next = LOOKUP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_ok = accept;
        data_ok = lookup_hit;
        rdata   = lookup_hit ? hit_word : rdata_q;
        rd_req  = (state == MISS);
        rd_type = RD_TYPE_LINE;
        rd_addr = (state == MISS) ? {tag_p1, index_p1, {OFFSET_W{1'b0}}} : 32'd0;
    end

    // Request stage: address fields captured on acceptance feed the lookup and refill.
    always_ff @(posedge aclk) begin
        if (accept) begin
            tag_p1   <= addr[31:OFFSET_W+INDEX_W];
            index_p1 <= addr[OFFSET_W+INDEX_W-1:OFFSET_W];
            word_p1  <= addr[OFFSET_W-1:2];
        end
        if (lookup_miss) begin
            victim_p1 <= !lv0 ? 1'b0 : (!lv1 ? 1'b1 : rr_ptr[index_p1]);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat    <= '0;
            rr_ptr  <= '0;
            rdata_q <= '0;
        end else begin
            if (fill_we) begin
                beat <= ret_last ? '0 : beat + 2'd1;
            end
            if (fill_last) begin
                rr_ptr[index_p1] <= ~rr_ptr[index_p1];
            end
            if (lookup_hit) begin
                rdata_q <= hit_word;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (lookup_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (lookup_miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

    icache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
        .aclk(aclk), .aresetn(aresetn),
        .rd_index(index_p1), .rd_word(word_p1), .cmp_tag(tag_p1),
        .line_valid(lv0), .hit(hit0), .rd_data(data0),
        .wr_en(fill_we && !victim_p1), .tag_en(fill_last && !victim_p1),
        .wr_index(index_p1), .wr_word(beat), .wr_data(ret_data), .wr_tag(tag_p1)
    );

    icache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
        .aclk(aclk), .aresetn(aresetn),
        .rd_index(index_p1), .rd_word(word_p1), .cmp_tag(tag_p1),
        .line_valid(lv1), .hit(hit1), .rd_data(data1),
        .wr_en(fill_we && victim_p1), .tag_en(fill_last && victim_p1),
        .wr_index(index_p1), .wr_word(beat), .wr_data(ret_data), .wr_tag(tag_p1)
    );

endmodule
